// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state enum, oversampling sample points and 8E1 frame constants.
// Ports: none. Macro RX_MAJORITY_EN moves the decision tick to os_cnt 8 (2-of-3 vote over 6/7/8).
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
    localparam int OS_RATE_DEF = 16;
    localparam int MAJ_FIRST   = 6;
`ifdef RX_MAJORITY_EN
    localparam int SAMPLE_PT   = 8;
`else
    localparam int SAMPLE_PT   = 7;
`endif
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic PAR_ODD   = 1'b0;
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_if: consumer-side holding register handshake of the receiver.
// Ports: data_out/rx_valid/parity_err/frame_err/overrun_err/rx_busy from the receiver (master), rx_ack from the consumer (slave).
interface uart_rx_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] data_out;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 rx_busy;
    modport master(output data_out, rx_valid, parity_err, frame_err, overrun_err, rx_busy, input rx_ack);
    modport slave(input data_out, rx_valid, parity_err, frame_err, overrun_err, rx_busy, output rx_ack);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divisor counter emitting a one-clk tick every div clocks (div 0 acts as 1).
// Ports: clk, rst (sync active-low), div (clocks per tick), clr (sync restart of the count), tick.
module uart_baud_tick #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             clr,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] lim;

    assign lim  = (div == '0) ? '0 : div - DIV_W'(1);
    assign tick = (cnt == lim);

    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + DIV_W'(1);
    end
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling 8E1 serial receiver with one-entry holding register and error status.
// Ports: clk, rst (sync active-low), baud_select (clocks per oversample tick), rx_enable (start
// detection gate), ser_in (async line, idle high), rx (uart_rx_if.master: data/valid/errors/busy, rx_ack).
// Macro RX_MAJORITY_EN: 2-of-3 majority over os_cnt 6/7/8 instead of a single sample at 7.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int OS_RATE   = OS_RATE_DEF,
    parameter int DIV_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_select,
    input  logic             rx_enable,
    input  logic             ser_in,
    uart_rx_if.master        rx
);
    localparam int OW = $clog2(OS_RATE);
    localparam int BW = $clog2(DATA_BITS);

    rx_state_t            state, state_nxt;
    logic                 ser_meta, ser_s, ser_prev;
    logic                 tick, samp_pt, sample, start_go;
    logic                 shift_en, par_en, commit, par_bad;
    logic [OW-1:0]        os_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_reg;

    assign start_go = (state == IDLE) && ser_prev && !ser_s && rx_enable;

    // Restarting the divider on the detected edge phase-aligns every sample point to it.
    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .div  (baud_select),
        .clr  (start_go),
        .tick (tick)
    );

`ifdef RX_MAJORITY_EN
    logic maj_a, maj_b;

    assign samp_pt = tick && (os_cnt == OW'(SAMPLE_PT));
    assign sample  = maj3(maj_a, maj_b, ser_s);

    always_ff @(posedge clk) begin
        if (!rst) begin
            maj_a <= 1'b1;
            maj_b <= 1'b1;
        end else if (tick && os_cnt == OW'(MAJ_FIRST))
            maj_a <= ser_s;
        else if (tick && os_cnt == OW'(MAJ_FIRST + 1))
            maj_b <= ser_s;
    end
`else
    assign samp_pt = tick && (os_cnt == OW'(SAMPLE_PT));
    assign sample  = ser_s;
`endif

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_go) state_nxt = START;
            START:   if (samp_pt) state_nxt = (sample == START_LVL) ? DATA : IDLE;
            DATA:    if (samp_pt && bit_idx == BW'(DATA_BITS - 1)) state_nxt = PARITY;
            PARITY:  if (samp_pt) state_nxt = STOP;
            STOP:    if (samp_pt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rx.rx_busy = (state != IDLE);
        shift_en   = (state == DATA) && samp_pt;
        par_en     = (state == PARITY) && samp_pt;
        commit     = (state == STOP) && samp_pt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ser_meta       <= 1'b1;
            ser_s          <= 1'b1;
            ser_prev       <= 1'b1;
            os_cnt         <= '0;
            bit_idx        <= '0;
            shift_reg      <= '0;
            par_bad        <= 1'b0;
            rx.data_out    <= '0;
            rx.rx_valid    <= 1'b0;
            rx.parity_err  <= 1'b0;
            rx.frame_err   <= 1'b0;
            rx.overrun_err <= 1'b0;
        end else begin
            ser_meta <= ser_in;
            ser_s    <= ser_meta;
            ser_prev <= ser_s;
            if (start_go) begin
                os_cnt  <= '0;
                bit_idx <= '0;
            end else if (tick)
                os_cnt <= (os_cnt == OW'(OS_RATE - 1)) ? '0 : os_cnt + OW'(1);
            if (shift_en) begin
                shift_reg[bit_idx] <= sample;
                bit_idx            <= bit_idx + BW'(1);
            end
            if (par_en)
                par_bad <= (^shift_reg) ^ sample ^ PAR_ODD;
            // A commit wins over an ack in the same cycle: the new byte stays held.
            if (commit) begin
                rx.data_out   <= shift_reg;
                rx.parity_err <= par_bad;
                rx.frame_err  <= (sample != STOP_LVL);
                rx.rx_valid   <= 1'b1;
                if (rx.rx_valid && !rx.rx_ack)
                    rx.overrun_err <= 1'b1;
            end else if (rx.rx_ack) begin
                rx.rx_valid    <= 1'b0;
                rx.overrun_err <= 1'b0;
                rx.parity_err  <= 1'b0;
                rx.frame_err   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed and randomized frames checked every cycle against a frame-level model.
module tb_uart_rx_os;
`ifdef RX_MAJORITY_EN
    localparam int SP = 8;
`else
    localparam int SP = 7;
`endif

    typedef struct {
        int         due;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_enable = 1'b1;
    logic       ser_in = 1'b1;
    logic [7:0] baud_select = 8'd4;

    uart_rx_if #(.DATA_BITS(8)) rx_if();

    uart_rx_os #(.DATA_BITS(8), .OS_RATE(16), .DIV_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_select (baud_select),
        .rx_enable   (rx_enable),
        .ser_in      (ser_in),
        .rx          (rx_if)
    );

    always #5 clk = ~clk;

    exp_t       q[$];
    int         cyc = 0, n_cmp = 0, n_bad = 0;
    int         busy_from = 0, busy_to = 0, last_start = 0, rise_cyc = 0;
    logic       ack_s = 1'b0, rst_s = 1'b0, prev_valid = 1'b0;
    logic [7:0] e_data = '0;
    logic       e_valid = 1'b0, e_pe = 1'b0, e_fe = 1'b0, e_ovr = 1'b0;
    bit         ack_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc   = cyc + 1;
        ack_s = rx_if.rx_ack;
        rst_s = rst;
    end

    // Model: frames become visible at their predicted commit cycle; acks and reset act on the last edge.
    always @(negedge clk) begin
        if (!rst_s) begin
            q.delete();
            e_valid = 0; e_pe = 0; e_fe = 0; e_ovr = 0; e_data = '0;
            busy_from = 0; busy_to = 0;
        end else if (q.size() > 0 && q[0].due == cyc) begin
            if (e_valid && !ack_s) e_ovr = 1;
            e_data  = q[0].d;
            e_pe    = q[0].pe;
            e_fe    = q[0].fe;
            e_valid = 1;
            void'(q.pop_front());
        end else if (ack_s) begin
            e_valid = 0; e_ovr = 0; e_pe = 0; e_fe = 0;
        end
        chk("rx_valid", rx_if.rx_valid, e_valid);
        chk("data_out", rx_if.data_out, e_valid ? e_data : rx_if.data_out ^ 8'h00);
        chk("parity_err", rx_if.parity_err, e_pe);
        chk("frame_err", rx_if.frame_err, e_fe);
        chk("overrun_err", rx_if.overrun_err, e_ovr);
        chk("rx_busy", rx_if.rx_busy, (cyc >= busy_from && cyc < busy_to) ? 1 : 0);
        if (!rst_s) chk("reset_data", rx_if.data_out, 0);
        if (rx_if.rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_if.rx_valid;
    end

    task automatic send(input logic [7:0] d, input logic pbit, input logic stop, input int hold);
        int          bsn = (baud_select == 0) ? 1 : int'(baud_select);
        int          bl  = 16 * bsn;
        logic [10:0] fr  = {stop, pbit, d, 1'b0};
        exp_t        e;
        @(posedge clk); #1;
        last_start = cyc;
        e.due = cyc + 3 + (16 * 10 + SP + 1) * bsn;
        e.d   = d;
        e.pe  = pbit ^ (^d);
        e.fe  = ~stop;
        q.push_back(e);
        busy_from = cyc + 3;
        busy_to   = e.due;
        for (int k = 0; k < 11; k++) begin
            ser_in = fr[k];
            repeat (bl) @(posedge clk);
            #1;
        end
        repeat (hold) @(posedge clk);
        #1 ser_in = 1'b1;
        repeat (bl) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        @(posedge clk); #1 rx_if.rx_ack = 1'b1;
        @(posedge clk); #1 rx_if.rx_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (ack_en) rx_if.rx_ack = ($urandom_range(0, 30) == 0);
        end
    end

    initial begin
        logic [7:0] d;
        logic       st;
        rx_if.rx_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("lit_reset_valid", rx_if.rx_valid, 0);
        send(8'hA5, 1'b0, 1'b1, 0);
        chk("lit_a5_data", rx_if.data_out, 8'hA5);
        chk("lit_a5_valid", rx_if.rx_valid, 1);
        chk("lit_a5_perr", rx_if.parity_err, 0);
        chk("lit_a5_latency", rise_cyc - last_start, (SP == 7) ? 675 : 679);
        pulse_ack();
        chk("lit_ack_clear", rx_if.rx_valid, 0);
        send(8'h01, 1'b0, 1'b1, 0);
        chk("lit_01_data", rx_if.data_out, 8'h01);
        chk("lit_01_perr", rx_if.parity_err, 1);
        chk("lit_01_ferr", rx_if.frame_err, 0);
        pulse_ack();
        send(8'h3C, 1'b0, 1'b0, 2000);
        chk("lit_3c_ferr", rx_if.frame_err, 1);
        chk("lit_3c_data", rx_if.data_out, 8'h3C);
        pulse_ack();
        @(posedge clk); #1 ser_in = 1'b0;
        busy_from = cyc + 3;
        busy_to   = cyc + 3 + (SP + 1) * 4;
        repeat (8) @(posedge clk);
        #1 ser_in = 1'b1;
        repeat (200) @(posedge clk);
        #1 chk("lit_glitch_valid", rx_if.rx_valid, 0);
        rx_enable = 1'b0;
        ser_in = 1'b0;
        repeat (100) @(posedge clk);
        #1 ser_in = 1'b1;
        repeat (100) @(posedge clk);
        #1 rx_enable = 1'b1;
        chk("lit_disabled_busy", rx_if.rx_busy, 0);
        send(8'h11, 1'b0, 1'b1, 0);
        send(8'h22, 1'b0, 1'b1, 0);
        chk("lit_ovr_data", rx_if.data_out, 8'h22);
        chk("lit_ovr_flag", rx_if.overrun_err, 1);
        pulse_ack();
        chk("lit_ovr_clear", rx_if.overrun_err, 0);
        chk("lit_ovr_valid", rx_if.rx_valid, 0);
        @(posedge clk); #1 ser_in = 1'b0;
        busy_from = cyc + 3;
        busy_to   = cyc + 100000;
        repeat (3 * 64) @(posedge clk);
        #1 rst = 1'b0;
        ser_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk("lit_rst_busy", rx_if.rx_busy, 0);
        repeat (20) @(posedge clk);
        send(8'h5A, 1'b0, 1'b1, 0);
        chk("lit_5a_data", rx_if.data_out, 8'h5A);
        chk("lit_5a_perr", rx_if.parity_err, 0);
        chk("lit_5a_ferr", rx_if.frame_err, 0);
        ack_en = 1'b1;
        for (int i = 0; i < 25; i++) begin
            baud_select = 8'($urandom_range(0, 4));
            d  = 8'($urandom);
            st = ($urandom_range(0, 4) != 0);
            send(d, (^d) ^ ($urandom_range(0, 3) == 0), st, st ? 0 : int'($urandom_range(0, 200)));
            repeat ($urandom_range(0, 50)) @(posedge clk);
            #1;
        end
        ack_en = 1'b0;
        @(posedge clk); #1 rx_if.rx_ack = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
